// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder: default geometry and the
// signed-overflow rule used by adder datapaths.
package add_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_CHUNK = 4;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit slice of the adder: a + b + ci, with the carry
// that enters the slice MSB exposed for overflow detection.
module add_chunk
    import add_pkg::*;
#(
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_in_o
);

    logic [CHUNK:0] total_s;

    assign total_s    = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
    assign s_o        = total_s[CHUNK-1:0];
    assign co_o       = total_s[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
    assign c_msb_in_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ s_o[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined A + B + Cin adder: one CHUNK-bit slice per stage, registered carry
// between stages, single global advance driven by output back-pressure.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("add_pipe: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic             adv_s;

    // Stage k registers: operands still to be summed (skew), finished low sum
    // chunks (deskew), carry into chunk k and the entry's valid bit.
    logic             v_q      [STAGES];
    logic [WIDTH-1:0] a_q      [STAGES];
    logic [WIDTH-1:0] b_q      [STAGES];
    logic [WIDTH-1:0] s_q      [STAGES];
    logic             c_q      [STAGES];

    logic [CHUNK-1:0] chunk_s  [STAGES];
    logic             co_s     [STAGES];
    logic             c_msb_s  [STAGES];
    logic [WIDTH-1:0] s_next_s [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;

    assign adv_s    = ~out_valid_q | out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a_i       (a_q[k][k*CHUNK +: CHUNK]),
            .b_i       (b_q[k][k*CHUNK +: CHUNK]),
            .ci_i      (c_q[k]),
            .s_o       (chunk_s[k]),
            .co_o      (co_s[k]),
            .c_msb_in_o(c_msb_s[k])
        );
    end

    // Merge each stage's freshly computed chunk into its running sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next_s[k]                   = s_q[k];
            s_next_s[k][k*CHUNK +: CHUNK] = chunk_s[k];
        end
    end

    // Output register next-state comes straight from the final stage.
    always_comb begin
        out_valid_d = v_q[LAST];
        sum_d       = s_next_s[LAST];
        cout_d      = co_s[LAST];
        ovf_d       = c_msb_s[LAST] ^ co_s[LAST];
    end

    // Pipeline and output registers; everything holds together when adv is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
                c_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv_s) begin
            v_q[0] <= in_valid;
            a_q[0] <= A;
            b_q[0] <= B;
            s_q[0] <= {WIDTH{1'b0}};
            c_q[0] <= Cin;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_next_s[k-1];
                c_q[k] <= co_s[k-1];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
